// File: rtl/xor3_bist_ctrl_if.sv
// Handshake and result bundle between the XOR3 BIST sequencer and its environment.
// slave: the sequencer; master: the surrounding lab top or bench.
interface xor3_bist_ctrl_if #(
    parameter int unsigned ERR_W = 4
);
    logic             start;
    logic             dut_y;
    logic             dut_a;
    logic             dut_b;
    logic             dut_c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       fail_vec;

    modport master (
        output start, dut_y,
        input  dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, dut_y,
        output dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/xor3_bist_ctrl.sv
// BIST sequencer for the 3-input XOR cell: walks all 8 vectors, checks odd parity.
// Optional: define XOR3_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module xor3_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 4
) (
    input logic            clk,
    input logic            rst,
    xor3_bist_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [7:0]       CntLoad = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ErrMax  = '1;

    state_e           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       pins_q, pins_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       fail_q, fail_d;
    logic             mismatch;
    logic             stop_on_fail;

    assign mismatch = bus.dut_y != (^vec_q);

`ifdef XOR3_BIST_STOP_ON_FAIL_EN
    assign stop_on_fail = mismatch;
`else
    assign stop_on_fail = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StSettle;
                    vec_d   = 3'd0;
                    cnt_d   = CntLoad;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            StSettle: begin
                if (cnt_q == 8'd0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StSample: begin
                if (mismatch) begin
                    fail_d[vec_q] = 1'b1;
                    if (err_q != ErrMax) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
                if (vec_q == 3'd7 || stop_on_fail) begin
                    state_d = StDone;
                end else begin
                    state_d = StSettle;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = CntLoad;
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are registered from the next state so they align with it.
        busy_d = (state_d == StSettle) || (state_d == StSample);
        done_d = (state_d == StDone);
        pins_d = busy_d ? vec_d : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            pins_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.dut_a     = pins_q[2];
    assign bus.dut_b     = pins_q[1];
    assign bus.dut_c     = pins_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = done_q && (err_q == '0);
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
endmodule

// File: tb/tb_xor3_bist_ctrl.sv
// Scoreboard bench for xor3_bist_ctrl: vector order/timing, result registers, reset abort.
module tb_xor3_bist_ctrl;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned EW     = 3;
`ifdef XOR3_BIST_STOP_ON_FAIL_EN
    localparam bit StopEn = 1'b1;
`else
    localparam bit StopEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;  // 0 golden, 1 stuck-at-0, 2 inverted
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];
    int   exp_err;
    logic [7:0] exp_fail;

    always #5 clk = ~clk;

    xor3_bist_ctrl_if #(.ERR_W(EW)) bus ();

    xor3_bist_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .ERR_W        (EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    assign bus.dut_y = (mode == 0) ? (bus.dut_a ^ bus.dut_b ^ bus.dut_c) :
                       (mode == 1) ? 1'b0 : ~(bus.dut_a ^ bus.dut_b ^ bus.dut_c);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cell_y(input int m, input int v);
        bit par;
        par = v[2] ^ v[1] ^ v[0];
        if (m == 0) return par;
        if (m == 1) return 1'b0;
        return ~par;
    endfunction

    // Builds the expected vector sequence and final results for one run.
    task automatic load_model(input int m);
        exp_q.delete();
        exp_err  = 0;
        exp_fail = 8'h00;
        for (int v = 0; v < 8; v++) begin
            bit mis;
            exp_q.push_back(v);
            mis = cell_y(m, v) != (v[2] ^ v[1] ^ v[0]);
            if (mis) begin
                exp_fail[v] = 1'b1;
                if (exp_err < (1 << EW) - 1) exp_err++;
            end
            if (mis && StopEn) break;
        end
    endtask

    task automatic check_outputs(input string tag, input int abc, input bit busy, input bit done);
        check({tag, ".abc"}, {29'd0, bus.dut_a, bus.dut_b, bus.dut_c}, abc);
        check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, busy});
        check({tag, ".done"}, {31'd0, bus.done}, {31'd0, done});
    endtask

    // Called at a negedge; pulses start, then follows the scoreboard cycle by cycle.
    task automatic run_bist(input int m, input int pulse_vec);
        bit first;
        mode = m;
        load_model(m);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("clr.err", {29'd0, bus.err_count}, 0);
        check("clr.fail", {24'd0, bus.fail_vec}, 0);
        first = 1'b1;
        while (exp_q.size() > 0) begin
            int v;
            v = exp_q.pop_front();
            for (int s = 0; s <= int'(SETTLE); s++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                bus.start = (v == pulse_vec && s == 0);
                check_outputs($sformatf("vec%0d.c%0d", v, s), v, 1'b1, 1'b0);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_outputs("end", 0, 1'b0, 1'b1);
        check("end.pass", {31'd0, bus.pass}, (exp_err == 0) ? 1 : 0);
        check("end.err", {29'd0, bus.err_count}, exp_err);
        check("end.fail", {24'd0, bus.fail_vec}, {24'd0, exp_fail});
    endtask

    task automatic check_all_zero(input string tag);
        check_outputs(tag, 0, 1'b0, 1'b0);
        check({tag, ".pass"}, {31'd0, bus.pass}, 0);
        check({tag, ".err"}, {29'd0, bus.err_count}, 0);
        check({tag, ".fail"}, {24'd0, bus.fail_vec}, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_bist(0, -1);
        run_bist(1, -1);
        run_bist(2, -1);
        // Restart from DONE with a start pulse during vector 3 that must be ignored.
        run_bist(0, 3);

        mode = 2;
        run_bist(2, -1);
        repeat (4) @(negedge clk);
        check("hold.done", {31'd0, bus.done}, 1);
        check("hold.err", {29'd0, bus.err_count}, exp_err);
        check("hold.fail", {24'd0, bus.fail_vec}, {24'd0, exp_fail});

        // Abort in SETTLE of vector 5 with an asynchronous reset.
        mode = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5 * (SETTLE + 1) + 1) @(negedge clk);
        check("pre_rst.abc", {29'd0, bus.dut_a, bus.dut_b, bus.dut_c}, 5);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("post_rst_idle");

        run_bist(1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
